// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One 1-bit full adder cell is reused for WIDTH cycles, LSB first. A
// three-state FSM (IDLE/RUN/DONE) sequences the operation. Results are
// published only at the completing edge and held until the next
// completion or reset.

// Single-bit full adder cell; the only arithmetic resource in the block.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Index is one bit wider than log2(WIDTH) so it can never wrap.
    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] psum_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] psum_next_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [IDX_W-1:0] idx_next_s;
    logic             last_bit_s;
    logic             ovf_s;

    fulladder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Datapath next-state for one serial step: shift in the new sum bit at
    // the MSB, shift operands right, advance the index. Overflow compares
    // the carry into the top bit (carry_r on the last step) with its carry out.
    always_comb begin
        psum_next_s = (psum_r >> 1'b1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
        a_next_s    = a_r >> 1'b1;
        b_next_s    = b_r >> 1'b1;
        idx_next_s  = idx_r + IDX_ONE;
        last_bit_s  = (idx_r == LAST_IDX);
        ovf_s       = carry_r ^ fa_cout_s;
    end

    // Control FSM, operand/carry/partial-sum registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx_r     <= '0;
            psum_r    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_RUN;
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= carry_in;
                        idx_r   <= '0;
                        psum_r  <= '0;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // start is deliberately not looked at here.
                    a_r     <= a_next_s;
                    b_r     <= b_next_s;
                    carry_r <= fa_cout_s;
                    idx_r   <= idx_next_s;
                    psum_r  <= psum_next_s;
                    if (last_bit_s) begin
                        state_r   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= psum_next_s;
                        carry_out <= fa_cout_s;
                        overflow  <= ovf_s;
                    end else begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Back-to-back: accept immediately, no second done.
                        state_r <= ST_RUN;
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= carry_in;
                        idx_r   <= '0;
                        psum_r  <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       carry_in = 1'b0;
    logic       busy, done, carry_out, overflow;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboards: {overflow, carry_out, sum}
    logic [9:0] q8[$];
    logic [2:0] q1[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .carry_in(cin1), .busy(busy1), .done(done1), .sum(sum1),
        .carry_out(cout1), .overflow(ovf1)
    );

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'h00, c};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t[8], t[7:0]};
    endfunction

    function automatic logic [2:0] model1(input logic x, input logic y, input logic c);
        logic [1:0] t;
        t = {1'b0, x} + {1'b0, y} + {1'b0, c};
        return {c ^ t[1], t[1], t[0]};
    endfunction

    // Drive a request on the 8-bit DUT (call at a negedge) and log the expectation.
    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c);
        a = x; b = y; carry_in = c; start = 1'b1;
        q8.push_back(model8(x, y, c));
    endtask

    // Release start, count busy cycles, then check the done cycle against the scoreboard.
    task automatic wait_op8(input string name);
        int n;
        logic [9:0] e;
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d expected 8", name, n);
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s done: got %b expected 1", name, done);
        end
        e = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
        tests_run++;
        if ({overflow, carry_out, sum} !== e) begin
            tests_failed++;
            $display("FAIL %s result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                     name, overflow, carry_out, sum, e[9], e[8], e[7:0]);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || {overflow, carry_out, sum} !== e) begin
            tests_failed++;
            $display("FAIL %s after_done: got done=%b busy=%b sum=%h expected done=0 busy=0 sum=%h",
                     name, done, busy, sum, e[7:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, done, sum, carry_out, overflow} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy, done, sum, carry_out, overflow);
        end
        tests_run++;
        if ({busy1, done1, sum1, cout1, ovf1} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b ovf=%b expected all 0",
                     busy1, done1, sum1, cout1, ovf1);
        end
        // Reset beats start in the same cycle.
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_priority: got busy=%b expected 0", busy);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [16:0] vec [4];
        vec[0] = {8'hFF, 8'h01, 1'b0};
        vec[1] = {8'h7F, 8'h01, 1'b0};
        vec[2] = {8'h80, 8'h80, 1'b1};
        vec[3] = {8'h00, 8'h00, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive8(vec[i][16:9], vec[i][8:1], vec[i][0]);
            wait_op8($sformatf("basic%0d", i));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_op8($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_hold_start();
        int n;
        logic [9:0] e;
        drive8(8'h12, 8'h34, 1'b1);
        @(negedge clk);
        a = 8'hAA;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (n !== 8 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_start_timing: got busy_cycles=%0d done=%b expected 8 1", n, done);
        end
        e = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
        tests_run++;
        if ({overflow, carry_out, sum} !== e || sum !== 8'h47) begin
            tests_failed++;
            $display("FAIL hold_start_sum: got sum=%h cout=%b expected sum=47 cout=%b", sum, carry_out, e[8]);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_start_norestart: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int hold_bad;
        logic [9:0] e;
        drive8(8'h01, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        e = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
        tests_run++;
        if (done !== 1'b1 || {overflow, carry_out, sum} !== e) begin
            tests_failed++;
            $display("FAIL b2b_first: got done=%b sum=%h expected done=1 sum=%h", done, sum, e[7:0]);
        end
        drive8(8'h03, 8'h04, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_restart: got busy=%b done=%b expected 1 0", busy, done);
        end
        hold_bad = 0;
        while (done !== 1'b1 && n < 64) begin
            if (sum !== 8'h02) hold_bad++;
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 9) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d cycles expected 9", n);
        end
        tests_run++;
        if (hold_bad !== 0) begin
            tests_failed++;
            $display("FAIL b2b_sum_hold: got %0d cycles without sum=02 expected 0", hold_bad);
        end
        e = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
        tests_run++;
        if ({overflow, carry_out, sum} !== e || sum !== 8'h07) begin
            tests_failed++;
            $display("FAIL b2b_second: got sum=%h expected 07", sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen;
        drive8(8'h55, 8'h33, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, sum, carry_out, overflow} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy, done, sum, carry_out, overflow);
        end
        reset = 1'b0;
        q8.delete();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0 || sum !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_abort_quiet: got %0d active cycles sum=%h expected 0 00", seen, sum);
        end
    endtask

    task automatic test_width1();
        logic [2:0] vec [3];
        logic [2:0] e;
        int n;
        vec[0] = 3'b110;
        vec[1] = 3'b101;
        vec[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            a1 = vec[i][2]; b1 = vec[i][1]; cin1 = vec[i][0]; start1 = 1'b1;
            q1.push_back(model1(vec[i][2], vec[i][1], vec[i][0]));
            @(negedge clk);
            start1 = 1'b0;
            n = 0;
            while (busy1 === 1'b1 && n < 16) begin
                n++;
                @(negedge clk);
            end
            e = (q1.size() > 0) ? q1.pop_front() : 3'b111;
            tests_run++;
            if (n !== 1 || done1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL w1_timing%0d: got busy_cycles=%0d done=%b expected 1 1", i, n, done1);
            end
            tests_run++;
            if ({ovf1, cout1, sum1} !== e) begin
                tests_failed++;
                $display("FAIL w1_result%0d: got ovf=%b cout=%b sum=%b expected ovf=%b cout=%b sum=%b",
                         i, ovf1, cout1, sum1, e[2], e[1], e[0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
